// File: rtl/soc_mmio_responder.sv
`default_nettype none
// ============================================================================
// soc_mmio_responder : MMIO request/response target over a local 64-bit memory
// Optional statistics counters: define MMIO_RESP_STATS_EN
// Revision: 1.0
// ============================================================================
module soc_mmio_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          MEM_AW    = 6,
  parameter int          RESP_LAT  = 2,
  parameter logic [31:0] STAT_ADDR = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        soc_req_val,
  output logic        soc_req_rdy,
  input  logic        soc_req_cmd,
  input  logic [31:0] soc_req_addr,
  input  logic [63:0] soc_req_data,
  output logic        soc_resp_val,
  input  logic        soc_resp_rdy,
  output logic        soc_resp_cmd,
  output logic [31:0] soc_resp_addr,
  output logic [63:0] soc_resp_data
);

  localparam logic [63:0] OOR_RDATA = 64'hDEAD_DEAD_DEAD_DEAD;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        cmd_q, cmd_d;
  logic [31:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] data_q, data_d;

  logic [63:0] mem [2**MEM_AW];

  logic [31:0]       mem_off;
  logic              in_range;
  logic [MEM_AW-1:0] mem_idx;
  logic              exec_done;
  logic              mem_we;
  logic              stat_hit;
  logic [63:0]       stat_rdata;

  assign mem_off   = addr_q - BASE_ADDR;
  assign in_range  = mem_off < (32'd1 << (MEM_AW + 3));
  assign mem_idx   = mem_off[MEM_AW+2:3];
  assign exec_done = (state_q == EXEC) && (cnt_q == 8'd0);
  // Reset gating keeps an abandoned write from committing on the reset edge.
  assign mem_we    = rst_n && exec_done && cmd_q && in_range && !stat_hit;

  assign soc_req_rdy   = rst_n && (state_q == IDLE);
  assign soc_resp_val  = (state_q == RESP);
  assign soc_resp_cmd  = cmd_q;
  assign soc_resp_addr = addr_q;
  assign soc_resp_data = data_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (soc_req_val) begin
          state_d = EXEC;
          cnt_d   = 8'(RESP_LAT);
          cmd_d   = soc_req_cmd;
          addr_d  = soc_req_addr;
          wdata_d = soc_req_data;
        end
      end
      EXEC: begin
        if (cnt_q == 8'd0) begin
          state_d = RESP;
          if (cmd_q)         data_d = 64'h0;
          else if (stat_hit) data_d = stat_rdata;
          else if (in_range) data_d = mem[mem_idx];
          else               data_d = OOR_RDATA;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: begin
        if (soc_resp_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      cmd_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 64'h0;
      data_q  <= 64'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= wdata_q;
  end

`ifdef MMIO_RESP_STATS_EN
  logic [31:0] stat_off;
  logic [1:0]  stat_idx;
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] oor_cnt_q, oor_cnt_d;

  assign stat_off = addr_q - STAT_ADDR;
  assign stat_hit = stat_off < 32'd24;
  assign stat_idx = stat_off[4:3];

  always_comb begin
    stat_rdata = 64'h0;
    case (stat_idx)
      2'd0:    stat_rdata = {32'h0, wr_cnt_q};
      2'd1:    stat_rdata = {32'h0, rd_cnt_q};
      2'd2:    stat_rdata = {32'h0, oor_cnt_q};
      default: stat_rdata = 64'h0;
    endcase
  end

  // Stat-register accesses clear on write and are never themselves counted.
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    oor_cnt_d = oor_cnt_q;
    if (exec_done) begin
      if (stat_hit) begin
        if (cmd_q) begin
          case (stat_idx)
            2'd0:    wr_cnt_d  = 32'h0;
            2'd1:    rd_cnt_d  = 32'h0;
            2'd2:    oor_cnt_d = 32'h0;
            default: ;
          endcase
        end
      end else if (in_range) begin
        if (cmd_q) wr_cnt_d = wr_cnt_q + 32'd1;
        else       rd_cnt_d = rd_cnt_q + 32'd1;
      end else begin
        oor_cnt_d = oor_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt_q  <= 32'h0;
      rd_cnt_q  <= 32'h0;
      oor_cnt_q <= 32'h0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      oor_cnt_q <= oor_cnt_d;
    end
  end
`else
  logic unused_stat_addr;
  assign stat_hit         = 1'b0;
  assign stat_rdata       = 64'h0;
  assign unused_stat_addr = ^STAT_ADDR;
`endif

endmodule
`default_nettype wire
